// File: rtl/filtros_pkg.sv
// filtros_pkg: definitions shared by the window memory arbiter.
//   estado_e        arbiter FSM state encoding (E_LIBRE=0, E_CAMBIO=1, E_ACCESO=2)
//   *_DEF           default values for the arbiter parameters
package filtros_pkg;

  typedef enum logic [1:0] {
    E_LIBRE  = 2'd0,
    E_CAMBIO = 2'd1,
    E_ACCESO = 2'd2
  } estado_e;

  localparam int unsigned N_VENTANAS_DEF = 4;
  localparam int unsigned ANCHO_DIR_DEF  = 16;
  localparam int unsigned MAX_RAFAGA_DEF = 8;

endpackage

// File: rtl/selector_round_robin.sv
// selector_round_robin: picks the first requesting window, starting the search at
// 'pointer' and wrapping from N_VENTANAS-1 back to 0. With pointer tied to zero it
// behaves as a fixed-priority (lowest index wins) selector.
//   solicitud  in   per-window request vector
//   pointer    in   index where the search starts
//   valido     out  at least one window is requesting
//   indice     out  index of the selected window (0 when valido is low)
module selector_round_robin import filtros_pkg::*; #(
  parameter int unsigned N_VENTANAS = N_VENTANAS_DEF,
  parameter int unsigned ANCHO_POS  = $clog2(N_VENTANAS)
) (
  input  logic [N_VENTANAS-1:0] solicitud,
  input  logic [ANCHO_POS-1:0]  pointer,
  output logic                  valido,
  output logic [ANCHO_POS-1:0]  indice
);

  logic [ANCHO_POS-1:0] candidato;
  logic                 encontrado;

  always_comb begin
    indice     = '0;
    encontrado = 1'b0;
    candidato  = pointer;
    for (int unsigned k = 0; k < N_VENTANAS; k++) begin
      if (!encontrado && solicitud[candidato]) begin
        encontrado = 1'b1;
        indice     = candidato;
      end
      candidato = (candidato == ANCHO_POS'(N_VENTANAS - 1)) ? '0 : candidato + 1'b1;
    end
  end

  assign valido = |solicitud;

endmodule

// File: rtl/arbitro_memoria_ventanas.sv
// arbitro_memoria_ventanas: arbitrates one memory bus among N_VENTANAS filter windows.
// Three Moore states: E_LIBRE (idle), E_CAMBIO (one-cycle bus reselection), E_ACCESO
// (grant, bounded to MAX_RAFAGA cycles per access).
//   clk               in   clock, rising edge
//   reset             in   asynchronous, active-low reset
//   solicitud         in   per-window level request
//   dir_ventana       in   packed window addresses, window i at [i*ANCHO_DIR +: ANCHO_DIR]
//   concesion         out  one-hot grant, zero when nobody owns the bus
//   posicion          out  index of the window selected for the bus
//   habilitar_cambio  out  pulse while the bus selection is updating (E_CAMBIO)
//   dir_memoria       out  address of the selected window
//   ocupado           out  arbiter not idle
// Build option: define ARBITRO_ROUND_ROBIN_EN for rotating-pointer selection;
// otherwise the lowest requesting index wins.
module arbitro_memoria_ventanas import filtros_pkg::*; #(
  parameter  int unsigned N_VENTANAS = N_VENTANAS_DEF,
  parameter  int unsigned ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter  int unsigned MAX_RAFAGA = MAX_RAFAGA_DEF,
  localparam int unsigned ANCHO_POS  = $clog2(N_VENTANAS),
  localparam int unsigned ANCHO_CNT  = $clog2(MAX_RAFAGA + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_VENTANAS-1:0]         solicitud,
  input  logic [N_VENTANAS*ANCHO_DIR-1:0] dir_ventana,
  output logic [N_VENTANAS-1:0]         concesion,
  output logic [ANCHO_POS-1:0]          posicion,
  output logic                          habilitar_cambio,
  output logic [ANCHO_DIR-1:0]          dir_memoria,
  output logic                          ocupado
);

  estado_e              estado_q, estado_d;
  logic [ANCHO_POS-1:0] posicion_q, posicion_d;
  logic [ANCHO_CNT-1:0] contador_q, contador_d;
  logic [ANCHO_POS-1:0] puntero_sel;
  logic                 sel_valido;
  logic [ANCHO_POS-1:0] sel_indice;

`ifdef ARBITRO_ROUND_ROBIN_EN
  logic [ANCHO_POS-1:0] puntero_q, puntero_d;
  assign puntero_sel = puntero_q;
`else
  assign puntero_sel = '0;
`endif

  selector_round_robin #(
    .N_VENTANAS (N_VENTANAS),
    .ANCHO_POS  (ANCHO_POS)
  ) u_selector (
    .solicitud (solicitud),
    .pointer   (puntero_sel),
    .valido    (sel_valido),
    .indice    (sel_indice)
  );

  always_comb begin
    estado_d         = estado_q;
    posicion_d       = posicion_q;
    contador_d       = contador_q;
`ifdef ARBITRO_ROUND_ROBIN_EN
    puntero_d        = puntero_q;
`endif
    concesion        = '0;
    habilitar_cambio = 1'b0;
    unique case (estado_q)
      E_LIBRE: begin
        if (sel_valido) begin
          posicion_d = sel_indice;
          estado_d   = E_CAMBIO;
        end
      end
      E_CAMBIO: begin
        habilitar_cambio = 1'b1;
        if (solicitud[posicion_q]) begin
          estado_d   = E_ACCESO;
          contador_d = '0;
`ifdef ARBITRO_ROUND_ROBIN_EN
          puntero_d  = (posicion_q == ANCHO_POS'(N_VENTANAS - 1)) ? '0 : posicion_q + 1'b1;
`endif
        end else begin
          // Request withdrawn before the grant: give the bus up without granting.
          estado_d = E_LIBRE;
        end
      end
      E_ACCESO: begin
        concesion[posicion_q] = 1'b1;
        if (!solicitud[posicion_q] || contador_q == ANCHO_CNT'(MAX_RAFAGA - 1)) begin
          // A departing window that dropped its request is already 0 in solicitud,
          // so the selector naturally skips it.
          if (sel_valido) begin
            posicion_d = sel_indice;
            estado_d   = E_CAMBIO;
          end else begin
            estado_d = E_LIBRE;
          end
        end else begin
          contador_d = contador_q + 1'b1;
        end
      end
      default: estado_d = E_LIBRE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= E_LIBRE;
      posicion_q <= '0;
      contador_q <= '0;
`ifdef ARBITRO_ROUND_ROBIN_EN
      puntero_q  <= '0;
`endif
    end else begin
      estado_q   <= estado_d;
      posicion_q <= posicion_d;
      contador_q <= contador_d;
`ifdef ARBITRO_ROUND_ROBIN_EN
      puntero_q  <= puntero_d;
`endif
    end
  end

  always_comb begin
    dir_memoria = '0;
    for (int unsigned i = 0; i < N_VENTANAS; i++) begin
      if (posicion_q == ANCHO_POS'(i)) begin
        dir_memoria = dir_ventana[i*ANCHO_DIR +: ANCHO_DIR];
      end
    end
  end

  assign posicion = posicion_q;
  assign ocupado  = (estado_q != E_LIBRE);

endmodule

// File: tb/tb_arbitro_memoria_ventanas.sv
// Scoreboard bench for arbitro_memoria_ventanas (N=4, ANCHO_DIR=16, MAX_RAFAGA=4).
// The driver steps a behavioural model of the arbitration rules on every cycle and
// queues the expected outputs; a separate monitor pops and compares after each edge.
module tb_arbitro_memoria_ventanas;

  localparam int N    = 4;
  localparam int A    = 16;
  localparam int MAXR = 4;
`ifdef ARBITRO_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   solicitud;
  logic [N*A-1:0] dir_ventana;
  logic [N-1:0]   concesion;
  logic [1:0]     posicion;
  logic           habilitar_cambio;
  logic [A-1:0]   dir_memoria;
  logic           ocupado;

  always #5 clk = ~clk;

  arbitro_memoria_ventanas #(
    .N_VENTANAS (N),
    .ANCHO_DIR  (A),
    .MAX_RAFAGA (MAXR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .solicitud        (solicitud),
    .dir_ventana      (dir_ventana),
    .concesion        (concesion),
    .posicion         (posicion),
    .habilitar_cambio (habilitar_cambio),
    .dir_memoria      (dir_memoria),
    .ocupado          (ocupado)
  );

  typedef struct packed {
    logic [3:0]  conc;
    logic [1:0]  pos;
    logic        hab;
    logic        ocu;
    logic [15:0] dir;
  } esp_t;

  esp_t cola[$];
  int   total = 0;
  int   bad   = 0;

  // Model: who owns the bus (-1 none), how many granted cycles it has used, whether
  // a reselection cycle is showing, the selected window and the search start.
  int m_dueno, m_usados, m_pos, m_ptr;
  bit m_cambio;

  task automatic comparar(input string nombre, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nombre, got, want, $time);
    end
  endtask

  task automatic modelo_reset();
    m_dueno  = -1;
    m_usados = 0;
    m_pos    = 0;
    m_ptr    = 0;
    m_cambio = 1'b0;
  endtask

  function automatic int ganador(input logic [3:0] s);
    int inicio = RR ? m_ptr : 0;
    for (int k = 0; k < N; k++) begin
      if (s[(inicio + k) % N]) return (inicio + k) % N;
    end
    return -1;
  endfunction

  task automatic modelo_paso(input logic [3:0] s);
    if (m_dueno >= 0) begin
      m_usados++;
      if (!s[m_dueno] || m_usados == MAXR) begin
        m_dueno = -1;
        if (s != 4'b0) begin
          m_pos    = ganador(s);
          m_cambio = 1'b1;
        end
      end
    end else if (m_cambio) begin
      m_cambio = 1'b0;
      if (s[m_pos]) begin
        m_dueno  = m_pos;
        m_usados = 0;
        m_ptr    = (m_pos + 1) % N;
      end
    end else if (s != 4'b0) begin
      m_pos    = ganador(s);
      m_cambio = 1'b1;
    end
  endtask

  task automatic ciclo(input logic [3:0] s);
    esp_t e;
    @(negedge clk);
    solicitud = s;
    if ($urandom_range(0, 7) == 0) dir_ventana = {$urandom, $urandom};
    modelo_paso(s);
    e.conc = (m_dueno >= 0) ? (4'b0001 << m_dueno) : 4'b0000;
    e.pos  = 2'(m_pos);
    e.hab  = m_cambio;
    e.ocu  = m_cambio || (m_dueno >= 0);
    e.dir  = dir_ventana[m_pos*A +: A];
    cola.push_back(e);
  endtask

  task automatic repetir(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) ciclo(s);
  endtask

  // Monitor
  initial begin
    esp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cola.size() > 0) begin
        e = cola.pop_front();
        comparar("concesion", 32'(concesion), 32'(e.conc));
        comparar("posicion", 32'(posicion), 32'(e.pos));
        comparar("habilitar_cambio", 32'(habilitar_cambio), 32'(e.hab));
        comparar("ocupado", 32'(ocupado), 32'(e.ocu));
        comparar("dir_memoria", 32'(dir_memoria), 32'(e.dir));
      end
    end
  end

  // Driver
  initial begin
    logic [3:0] s;
    reset       = 1'b0;
    solicitud   = '0;
    dir_ventana = {$urandom, $urandom};
    modelo_reset();
    #1;
    comparar("reset_concesion", 32'(concesion), 32'd0);
    comparar("reset_posicion", 32'(posicion), 32'd0);
    comparar("reset_habilitar", 32'(habilitar_cambio), 32'd0);
    comparar("reset_ocupado", 32'(ocupado), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Single requester held: reselection then grant of window 1.
    repeat_idle: begin end
    repetir(4'b0010, 5);
    repetir(4'b0000, 3);
    // One-cycle pulse: reselection without grant.
    repetir(4'b0001, 1);
    repetir(4'b0000, 3);
    // All requesting: bursts bounded by MAX_RAFAGA.
    repetir(4'b1111, 22);
    repetir(4'b0000, 3);
    // Two requesters held, then the lower one withdraws.
    repetir(4'b1010, 15);
    repetir(4'b1000, 6);
    repetir(4'b0000, 3);
    // Window 2 drops mid-burst while window 0 waits.
    repetir(4'b0100, 3);
    repetir(4'b0101, 1);
    repetir(4'b0001, 6);
    repetir(4'b0000, 3);

    // Asynchronous reset while window 2 is granted.
    repetir(4'b0100, 3);
    @(negedge clk);
    #2;
    comparar("pre_reset_concesion", 32'(concesion), 32'b0100);
    reset = 1'b0;
    #1;
    comparar("async_concesion", 32'(concesion), 32'd0);
    comparar("async_posicion", 32'(posicion), 32'd0);
    comparar("async_ocupado", 32'(ocupado), 32'd0);
    comparar("async_habilitar", 32'(habilitar_cambio), 32'd0);
    modelo_reset();
    solicitud = '0;
    @(negedge clk);
    reset = 1'b1;
    // First arbitration after reset starts from window 0.
    repetir(4'b1111, 6);

    // Random traffic: requests toggle occasionally so bursts run long enough.
    s = 4'(solicitud);
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) s[b] = ~s[b];
      end
      ciclo(s);
    end
    repetir(4'b0000, 3);

    @(negedge clk);
    comparar("cola_vacia", 32'(cola.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
